lc3_fetch_stage: RTL and testbench

// - LC-3 fetch stage, directly upstream of decode. Owns the PC and issues reads to instruction memory.
// - Delivers each fetched instruction to decode on the decode_in bus: enable_decode, dout, npc_in.
// - Applies redirects from writeback/control (br_taken/taddr) and squashes the read in flight.

---
 rtl/lc3_fetch_stage.sv | 101 ++++++++++
 tb/tb_lc3_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_fetch_stage.sv
// LC-3 fetch stage: owns the PC, issues imem reads, delivers instructions to decode.
// Optional LC3_FETCH_STATS_EN adds saturating fetch/squash counters.
module lc3_fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'('h3000)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_fetch,
  input  logic                enable_updatePC,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] taddr,
  output logic                instrmem_rd,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] imem_dout,
  output logic                enable_decode,
  output logic [PC_WIDTH-1:0] dout,
  output logic [PC_WIDTH-1:0] npc_in
`ifdef LC3_FETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         squash_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SQUASH
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                redirect;
  logic                squash;
  logic                issued_q;
  logic [PC_WIDTH-1:0] npc_q;
  logic [PC_WIDTH-1:0] pc_nxt;

  assign redirect    = enable_updatePC & br_taken;
  assign instrmem_rd = enable_fetch & (state != IDLE);
  assign squash      = (state == SQUASH);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        state_nxt = RUN;
      RUN, SQUASH: state_nxt = (redirect && instrmem_rd) ? SQUASH : RUN;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (redirect)
      pc_nxt = taddr;
    else if (enable_updatePC)
      pc_nxt = pc + PC_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      issued_q      <= 1'b0;
      npc_q         <= '0;
      enable_decode <= 1'b0;
      dout          <= '0;
      npc_in        <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      issued_q <= instrmem_rd;
      if (instrmem_rd)
        npc_q <= pc + PC_WIDTH'(1);
      // A read issued alongside a redirect returns a wrong-path word
      if (issued_q && !squash) begin
        enable_decode <= 1'b1;
        dout          <= imem_dout;
        npc_in        <= npc_q;
      end else begin
        enable_decode <= 1'b0;
      end
    end
  end

`ifdef LC3_FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (enable_decode && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (issued_q && squash && squash_count != 32'hFFFF_FFFF)
        squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Randomized + directed bench for lc3_fetch_stage against a delivery-queue model.
module tb_lc3_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        enable_updatePC = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [15:0] imem_dout;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
`ifdef LC3_FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  always #5 clock = ~clock;

  lc3_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .enable_fetch   (enable_fetch),
    .enable_updatePC(enable_updatePC),
    .br_taken       (br_taken),
    .taddr          (taddr),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .imem_dout      (imem_dout),
    .enable_decode  (enable_decode),
    .dout           (dout),
    .npc_in         (npc_in)
`ifdef LC3_FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .squash_count   (squash_count)
`endif
  );

  // instruction memory: data for the address read one cycle earlier
  logic [15:0] mem [0:65535];
  logic [15:0] rd_addr = '0;
  always @(posedge clock) if (instrmem_rd) rd_addr <= pc;
  assign imem_dout = mem[rd_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] npc;
    logic [15:0] data;
    bit          drop;
  } item_t;

  item_t       q[$];
  logic [15:0] m_pc = '0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_npc = '0;
  bit          m_en = 0;
  bit          m_started = 0;
  bit          m_known = 0;
  logic [31:0] m_fc = '0;
  logic [31:0] m_sc = '0;
  int          n = 0;

  task automatic step(input bit r, input bit ef, input bit eu, input bit bt,
                      input logic [15:0] ta);
    bit rd;
    bit redir;
    item_t it;
    reset = r;
    enable_fetch = ef;
    enable_updatePC = eu;
    br_taken = bt;
    taddr = ta;
    #1;
    rd = ef && m_started;
    redir = eu && bt;
    if (m_known) begin
      chk("rd", instrmem_rd, rd);
      chk("pc", pc, m_pc);
    end
    @(posedge clock);
    if (r) begin
      q.delete();
      m_pc = 16'h3000;
      m_en = 0;
      m_dout = '0;
      m_npc = '0;
      m_fc = '0;
      m_sc = '0;
      m_started = 0;
      m_known = 1;
    end else begin
      if (m_en && m_fc != 32'hFFFF_FFFF) m_fc++;
      m_en = 0;
      if (q.size() > 0 && q[0].due == n) begin
        it = q.pop_front();
        if (it.drop) begin
          if (m_sc != 32'hFFFF_FFFF) m_sc++;
        end else begin
          m_en = 1;
          m_dout = it.data;
          m_npc = it.npc;
        end
      end
      if (rd) begin
        it.due = n + 1;
        it.npc = m_pc + 16'd1;
        it.data = mem[m_pc];
        it.drop = redir;
        q.push_back(it);
      end
      if (redir) m_pc = ta;
      else if (eu) m_pc = m_pc + 16'd1;
      m_started = 1;
    end
    n++;
    @(negedge clock);
    chk("en", enable_decode, m_en);
    chk("dout", dout, m_dout);
    chk("npc", npc_in, m_npc);
`ifdef LC3_FETCH_STATS_EN
    chk("fcnt", fetch_count, m_fc);
    chk("scnt", squash_count, m_sc);
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h3000] = 16'h1234;
    mem[16'h3001] = 16'h5678;
    mem[16'h3002] = 16'h9ABC;

    // reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("idle_pc", pc, 16'h3000);
    chk("idle_en", enable_decode, 0);
    chk("idle_rd", instrmem_rd, 0);

    // sequential fetch of three words
    repeat (3) step(0, 1, 1, 0, 0);
    chk("seq_dout2", dout, 16'h5678);
    chk("seq_npc2", npc_in, 16'h3002);
    step(0, 0, 0, 0, 0);
    chk("seq_en3", enable_decode, 1);
    chk("seq_dout3", dout, 16'h9ABC);
    chk("seq_npc3", npc_in, 16'h3003);
    step(0, 0, 0, 0, 0);
    chk("seq_hold", dout, 16'h9ABC);

    // redirect while 3002 is issued
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 16'h4000);
    step(0, 1, 1, 0, 0);
    chk("sq_en", enable_decode, 0);
    step(0, 1, 1, 0, 0);
    chk("br_npc", npc_in, 16'h4001);
`ifdef LC3_FETCH_STATS_EN
    chk("br_scnt", squash_count, 1);
`endif
    repeat (2) step(0, 0, 0, 0, 0);

    // stall mid-stream
    repeat (2) step(0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);

    // wrap at 16'hFFFF
    step(0, 0, 1, 1, 16'hFFFF);
    step(0, 1, 1, 0, 0);
    chk("wrap_pc", pc, 16'h0000);
    step(0, 1, 1, 0, 0);
    chk("wrap_npc", npc_in, 16'h0000);

    // reset with reads in flight
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_en", enable_decode, 0);
    chk("rst_pc", pc, 16'h3000);
    step(0, 1, 1, 0, 0);
    chk("rst_stale", enable_decode, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ta;
      ta = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                      : 16'($urandom);
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           ta);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
